instr_fetch: RTL and testbench

Instruction-fetch stage of the multicycle processor, directly upstream of the instruction decoder. It owns the program counter and the instruction register. On a request from the control sequencer it performs one handshake with instruction memory and latches the returned word into the instruction register, which drives the decoder's `instruction` input. It also accepts branch and jump redirects, including word-index jump targets as produced by the decoder.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_watchdog.sv | 54 +++++
 rtl/instr_fetch.sv | 155 +++++++++++++++
 tb/tb_instr_fetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (IDLE / REQ / WAIT)
//   WORD_BYTES    : PC increment per fetched instruction
//   INSTR_RESET   : instruction register value after reset
//   align_target  : converts a redirect target (word index or byte address)
//                   into a word-aligned byte address
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    localparam int unsigned WORD_BYTES  = 4;
    localparam logic [31:0] INSTR_RESET = 32'h0000_0000;

    // Word indices are scaled by 4. Byte addresses have their low two bits
    // dropped, so the PC can never become misaligned.
    function automatic logic [31:0] align_target(input logic [31:0] raw,
                                                 input logic        is_word);
        return is_word ? {raw[29:0], 2'b00} : {raw[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// -----------------------------------------------------------------------------
// fetch_watchdog
// Bounds the time the fetch FSM can spend in WAIT. The down-counter loads on
// WAIT entry and decrements on every WAIT cycle that has no memory response.
// The terminal count raises a one-cycle timeout and sets a sticky error flag.
// The flag stays set until rst.
// Only instantiated when INSTR_FETCH_TIMEOUT_EN is defined.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : FSM is in REQ, so WAIT begins next cycle
//   wait_i     : FSM is in WAIT
//   valid_i    : memory response this cycle
//   timeout_o  : combinational, this WAIT cycle is the last one allowed
//   err_o      : sticky registered error flag
// -----------------------------------------------------------------------------
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic wait_i,
    input  logic valid_i,
    output logic timeout_o,
    output logic err_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    // A count of zero in WAIT means TIMEOUT_CYCLES empty WAIT cycles, this
    // one included.
    assign timeout_o = wait_i && !valid_i && (cnt_q == '0);
    assign err_o     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (load_i) begin
                cnt_q <= CW'(TIMEOUT_CYCLES - 1);
            end else if (wait_i && !valid_i && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (timeout_o) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage of the multicycle processor. It owns the PC and the
// instruction register. Each fetch request performs one memory handshake.
// Branch and jump redirects can be given as a byte address or a word index.
//
// Optional feature: define INSTR_FETCH_TIMEOUT_EN to add the WAIT watchdog
// (fetch_watchdog) and the sticky fetch_err flag. Without the macro, fetch_err
// is tied to 0 and WAIT has no time limit.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   fetch_en                     start one fetch (sampled in IDLE only)
//   redirect_valid/_word/_pc     load a new PC (word index when _word=1)
//   imem_req, imem_addr          one-cycle read strobe and address (= pc)
//   imem_valid, imem_rdata       read response
//   instr, instr_valid           instruction register and its update pulse
//   pc, pc_plus4                 current PC and pc+4 (combinational)
//   busy                         high in REQ and WAIT
//   fetch_err                    sticky watchdog error
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | waiting for fetch_en; redirects load pc directly
// ST_REQ  | imem_req high for one cycle with imem_addr = pc
// ST_WAIT | waiting for imem_valid; redirects are held as pending
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic        redirect_word,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        fetch_err
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         instr_valid_q;
    logic         imem_req_q;
    logic         busy_q;
    logic         pend_valid_q;
    logic [31:0]  pend_pc_q;

    logic [31:0]  target_d;
    logic         wd_timeout;

    assign target_d    = align_target(redirect_pc, redirect_word);
    assign pc_plus4    = pc_q + WORD_BYTES;
    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;

`ifdef INSTR_FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == ST_REQ),
        .wait_i    (state_q == ST_WAIT),
        .valid_i   (imem_valid),
        .timeout_o (wd_timeout),
        .err_o     (fetch_err)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wd_timeout         = 1'b0;
    assign fetch_err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= INSTR_RESET;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= '0;
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A redirect and a fetch in the same cycle: the fetch
                    // leaves REQ with the redirected PC.
                    if (redirect_valid) begin
                        pc_q <= target_d;
                    end
                    if (fetch_en) begin
                        state_q    <= ST_REQ;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state_q    <= ST_WAIT;
                    imem_req_q <= 1'b0;
                    if (redirect_valid) begin
                        pend_valid_q <= 1'b1;
                        pend_pc_q    <= target_d;
                    end
                end
                ST_WAIT: begin
                    if (imem_valid || wd_timeout) begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        pend_valid_q <= 1'b0;
                        // A redirect in this cycle is newer than the pending
                        // one. Any redirect discards the response.
                        if (redirect_valid) begin
                            pc_q <= target_d;
                        end else if (pend_valid_q) begin
                            pc_q <= pend_pc_q;
                        end else if (imem_valid) begin
                            instr_q       <= imem_rdata;
                            pc_q          <= pc_plus4;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        pend_valid_q <= 1'b1;
                        pend_pc_q    <= target_d;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    imem_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed testbench for instr_fetch. A transaction-level model (exp_* values,
// updated by the stimulus tasks) is compared with the DUT on every falling
// edge. Literal checks pin the model at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic        redirect_word;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        fetch_err;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_word  (redirect_word),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .busy           (busy),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_pc    = 32'h0;
    logic [31:0] exp_instr = 32'h0;
    logic        exp_iv    = 1'b0;
    logic        exp_req   = 1'b0;
    logic        exp_busy  = 1'b0;
    logic        exp_err   = 1'b0;
    bit          check_en  = 1'b0;

    int          cyc      = 0;
    int          t_iv     = -1;
    int          t_start  = 0;
    logic [31:0] last_req_addr = 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Redirect target from the specification's arithmetic, not the bit slicing.
    function automatic logic [31:0] tgt(input logic [31:0] raw, input bit is_word);
        return is_word ? raw * 32'd4 : raw - (raw % 32'd4);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (imem_req) last_req_addr = imem_addr;
        if (instr_valid) t_iv = cyc;
        if (check_en) begin
            chk("pc", pc, exp_pc);
            chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("instr", instr, exp_instr);
            chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("fetch_err", 32'(fetch_err), 32'(exp_err));
            if (exp_req) chk("imem_addr", imem_addr, exp_pc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_iv = 1'b0;
    endtask

    // One complete fetch starting in IDLE. The call returns in the
    // instr_valid cycle. nwait is the number of empty WAIT cycles before the
    // response. noise keeps fetch_en high past IDLE and pulses imem_valid in
    // REQ, and both must be ignored.
    task automatic do_fetch(input logic [31:0] data, input int nwait, input bit noise,
                            input bit redir, input bit rword, input logic [31:0] rpc);
        t_start = cyc + 1;
        fetch_en = 1'b1;
        redirect_valid = redir;
        redirect_word = rword;
        redirect_pc = rpc;
        step();
        if (redir) exp_pc = tgt(rpc, rword);
        exp_req = 1'b1;
        exp_busy = 1'b1;
        redirect_valid = 1'b0;
        if (noise) begin
            imem_valid = 1'b1;
            imem_rdata = 32'hBAD0_0BAD;
        end else begin
            fetch_en = 1'b0;
        end
        step();
        exp_req = 1'b0;
        imem_valid = 1'b0;
        repeat (nwait) step();
        imem_valid = 1'b1;
        imem_rdata = data;
        step();
        imem_valid = 1'b0;
        fetch_en = 1'b0;
        exp_instr = data;
        exp_pc = exp_pc + 32'd4;
        exp_iv = 1'b1;
        exp_busy = 1'b0;
    endtask

    task automatic start_to_wait();
        fetch_en = 1'b1;
        step();
        exp_req = 1'b1;
        exp_busy = 1'b1;
        fetch_en = 1'b0;
        step();
        exp_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_word = 1'b0;
        redirect_pc = 32'h0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        step();
        check_en = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_pc", pc, 32'h0);
        chk("reset_instr", instr, 32'h0);

        // Reset then fetch, 1-cycle memory.
        do_fetch(32'h0441_0005, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1_addr", last_req_addr, 32'h0);
        chk("t1_instr", instr, 32'h0441_0005);
        chk("t1_pc", pc, 32'h4);
        step();
        chk("t1_latency", 32'(t_iv - t_start), 32'd3);

        // Word-index jump together with fetch_en.
        do_fetch(32'h1111_1111, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
        chk("t2_addr", last_req_addr, 32'h0000_0100);
        chk("t2_pc", pc, 32'h0000_0104);

        // Back-to-back fetch from the instr_valid cycle, slow memory, ignored inputs.
        do_fetch(32'h2222_2222, 2, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3_addr", last_req_addr, 32'h0000_0104);
        chk("t3_pc", pc, 32'h0000_0108);
        chk("t3_instr", instr, 32'h2222_2222);

        // Redirect to byte address 0x200 (low bits set) during WAIT.
        start_to_wait();
        redirect_valid = 1'b1;
        redirect_word = 1'b0;
        redirect_pc = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_valid = 1'b0;
        exp_pc = tgt(32'h0000_0203, 1'b0);
        exp_busy = 1'b0;
        chk("t4_pc", pc, 32'h0000_0200);
        chk("t4_instr", instr, 32'h2222_2222);
        chk("t4_iv", 32'(instr_valid), 32'd0);

        // Redirect in REQ is superseded by a word redirect that arrives with imem_valid.
        fetch_en = 1'b1;
        step();
        exp_req = 1'b1;
        exp_busy = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_word = 1'b0;
        redirect_pc = 32'h0000_0300;
        step();
        exp_req = 1'b0;
        redirect_word = 1'b1;
        redirect_pc = 32'h0000_0050;
        imem_valid = 1'b1;
        imem_rdata = 32'h3333_3333;
        step();
        redirect_valid = 1'b0;
        imem_valid = 1'b0;
        exp_pc = tgt(32'h0000_0050, 1'b1);
        exp_busy = 1'b0;
        chk("t5_pc", pc, 32'h0000_0140);
        chk("t5_instr", instr, 32'h2222_2222);

        // Redirect in IDLE, then a fetch that wraps the PC.
        redirect_valid = 1'b1;
        redirect_word = 1'b0;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        exp_pc = tgt(32'hFFFF_FFFE, 1'b0);
        chk("t6_pc_redir", pc, 32'hFFFF_FFFC);
        chk("t6_p4_wrap", pc_plus4, 32'h0);
        do_fetch(32'h4444_4444, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6_pc_wrap", pc, 32'h0);
        chk("t6_p4", pc_plus4, 32'h4);

        // Reset mid-WAIT, then a late response.
        step();
        start_to_wait();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_pc = 32'h0;
        exp_instr = 32'h0;
        exp_busy = 1'b0;
        exp_err = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'h5555_5555;
        step();
        imem_valid = 1'b0;
        chk("t7_instr", instr, 32'h0);
        chk("t7_pc", pc, 32'h0);
        chk("t7_iv", 32'(instr_valid), 32'd0);
        do_fetch(32'h6666_6666, 1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t7_refetch_pc", pc, 32'h4);

`ifdef INSTR_FETCH_TIMEOUT_EN
        // Watchdog: 16 empty WAIT cycles end the fetch with a sticky error.
        step();
        start_to_wait();
        repeat (15) step();
        step();
        exp_busy = 1'b0;
        exp_err = 1'b1;
        chk("t8_err", 32'(fetch_err), 32'd1);
        chk("t8_pc", pc, 32'h4);
        do_fetch(32'h7777_7777, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t8_err_hold", 32'(fetch_err), 32'd1);
`endif

        step();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
